// File: rtl/fetch_unit_pkg.sv
// Shared parameters for the fetch unit: default address/instruction widths
// (stored as MSB index, so a bus is [SIZE:0]) and the FSM state encodings.
package fetch_unit_pkg;

   localparam int ADDR_SIZE  = 31;
   localparam int INSTR_SIZE = 31;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_REQ   = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
   localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
   localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory, a
// one-entry buffer to absorb a response that arrives while decode is stalled,
// and a redirect (flush) path that drains any stale in-flight response.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (word-aligns redirect targets
// and pulses fetch_misalign when the target had its low bits set).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ADDR_SZ  = ADDR_SIZE,
   parameter int          INSTR_SZ = INSTR_SIZE,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                flush,
   input  logic [ADDR_SZ:0]    flush_pc,
   output logic                imem_req_valid,
   output logic [ADDR_SZ:0]    imem_req_addr,
   input  logic                imem_req_ready,
   input  logic                imem_resp_valid,
   input  logic [INSTR_SZ:0]   imem_resp_data,
   output logic [ADDR_SZ:0]    PC_out,
   output logic [INSTR_SZ:0]   instr_out,
   output logic                pipeline_out_valid,
   output logic                fetch_misalign
);

   localparam logic [ADDR_SZ:0] PC_RST  = (ADDR_SZ+1)'(RESET_PC);
   localparam logic [ADDR_SZ:0] PC_INCR = (ADDR_SZ+1)'(PC_STEP);

   logic [ST_W-1:0]   state;
   logic [ST_W-1:0]   state_nxt;
   logic [ADDR_SZ:0]  fetch_pc;
   logic [ADDR_SZ:0]  redirect_pc;

   logic [ADDR_SZ:0]  out_pc;
   logic [INSTR_SZ:0] out_instr;
   logic              out_valid;

   logic              buf_valid;
   logic [ADDR_SZ:0]  buf_pc;
   logic [INSTR_SZ:0] buf_instr;

   logic              req_fire;
   logic              load_resp;
   logic              load_buf;
   logic              cap_buf;
   logic              load;

   assign imem_req_valid     = (state == ST_REQ);
   assign imem_req_addr      = fetch_pc;
   assign req_fire           = imem_req_valid && imem_req_ready;
   assign load               = load_resp || load_buf;

   assign PC_out             = out_pc;
   assign instr_out          = out_instr;
   assign pipeline_out_valid = out_valid;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign;

   assign redirect_pc    = {flush_pc[ADDR_SZ:2], 2'b00};
   assign fetch_misalign = misalign;

   // One-cycle pulse after a redirect to a non word-aligned target.
   always_ff @(posedge clk) begin
      if (reset)
         misalign <= 1'b0;
      else
         misalign <= flush && (flush_pc[1:0] != 2'b00);
   end
`else
   assign redirect_pc    = flush_pc;
   assign fetch_misalign = 1'b0;
`endif

   // Next-state and load decisions; flush overrides every normal transition.
   always_comb begin
      state_nxt = state;
      load_resp = 1'b0;
      load_buf  = 1'b0;
      cap_buf   = 1'b0;
      case (state)
         ST_IDLE:  state_nxt = ST_REQ;
         ST_REQ:   if (req_fire) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (imem_resp_valid) begin
               if (!stall) begin
                  load_resp = 1'b1;
                  state_nxt = ST_REQ;
               end else begin
                  cap_buf   = 1'b1;
                  state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!stall && buf_valid) begin
               load_buf  = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_DRAIN: if (imem_resp_valid) state_nxt = ST_REQ;
         default:  state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         load_resp = 1'b0;
         load_buf  = 1'b0;
         cap_buf   = 1'b0;
         // A response is still owed if a request was just accepted, or one
         // is outstanding and has not come back this cycle.
         if (req_fire || (((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_resp_valid))
            state_nxt = ST_DRAIN;
         else
            state_nxt = ST_REQ;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Fetch PC: redirect on flush, advance once per instruction handed to decode.
   always_ff @(posedge clk) begin
      if (reset)
         fetch_pc <= PC_RST;
      else if (flush)
         fetch_pc <= redirect_pc;
      else if (load)
         fetch_pc <= fetch_pc + PC_INCR;
   end

   // Output register to decode: load, hold under stall, or bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_pc    <= '0;
         out_instr <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_resp) begin
         out_pc    <= fetch_pc;
         out_instr <= imem_resp_data;
         out_valid <= 1'b1;
      end else if (load_buf) begin
         out_pc    <= buf_pc;
         out_instr <= buf_instr;
         out_valid <= 1'b1;
      end else if (!stall) begin
         out_valid <= 1'b0;
      end
   end

   // Skid buffer: catches the unstoppable response while decode is stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_pc    <= '0;
         buf_instr <= '0;
      end else if (flush) begin
         buf_valid <= 1'b0;
      end else if (cap_buf) begin
         buf_valid <= 1'b1;
         buf_pc    <= fetch_pc;
         buf_instr <= imem_resp_data;
      end else if (load_buf) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model,
// per-cycle compare process, directed scenarios with literal expectations.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int AW = ADDR_SIZE + 1;
   localparam int IW = INSTR_SIZE + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1, stall = 1'b0, flush = 1'b0, ready = 1'b1;
   logic [AW-1:0] flush_pc = '0;
   logic          resp_valid = 1'b0;
   logic [IW-1:0] resp_data = '0;
   logic          imem_req_valid, pipeline_out_valid, fetch_misalign;
   logic [AW-1:0] imem_req_addr, PC_out;
   logic [IW-1:0] instr_out;

   logic          resp_valid2 = 1'b0;
   logic [IW-1:0] resp_data2 = '0;
   logic          req_valid2, pov2, mis2;
   logic [7:0]    req_addr2, pc_out2;
   logic [IW-1:0] instr2;

   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(ready), .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
      .PC_out(PC_out), .instr_out(instr_out), .pipeline_out_valid(pipeline_out_valid),
      .fetch_misalign(fetch_misalign));

   fetch_unit #(.ADDR_SZ(7), .RESET_PC(32'hFC)) dut2 (
      .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .flush_pc(8'h00),
      .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
      .imem_req_ready(1'b1), .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
      .PC_out(pc_out2), .instr_out(instr2), .pipeline_out_valid(pov2),
      .fetch_misalign(mis2));

   int errors = 0, checks = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
      return IW'(a) ^ 32'hC0DE_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- instruction memory (configurable latency) -------------
   int            lat = 1;
   logic          m_hs, m_rst, m_pend = 1'b0, m_hs2;
   int            m_cnt = 0;
   logic [AW-1:0] m_a, m_pa;
   logic [7:0]    m_a2;

   initial begin
      forever begin
         @(negedge clk);
         m_hs  = imem_req_valid && ready;
         m_a   = imem_req_addr;
         m_rst = reset;
         m_hs2 = req_valid2;
         m_a2  = req_addr2;
         @(posedge clk);
         #1;
         resp_valid  = 1'b0;
         resp_valid2 = 1'b0;
         if (m_rst) begin
            m_pend = 1'b0;
         end else begin
            if (m_hs) begin
               m_pend = 1'b1;
               m_cnt  = lat;
               m_pa   = m_a;
            end
            if (m_pend) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  resp_valid = 1'b1;
                  resp_data  = mem_word(m_pa);
                  m_pend     = 1'b0;
               end
            end
            if (m_hs2) begin
               resp_valid2 = 1'b1;
               resp_data2  = mem_word({24'b0, m_a2});
            end
         end
      end
   end

   // ---------------- reference model ----------------------------------------
   // Tracks the fetch PC, whether a response is owed (and whether it must be
   // thrown away), the one-entry buffer and the decode-facing register.
   logic          m_init = 1'b0, m_idle, m_busy, m_drop, m_bv, m_ov, m_mis;
   logic [31:0]   m_pc, m_bpc, m_opc;
   logic [IW-1:0] m_bin, m_oin;

   function automatic logic exp_req();
      return !m_idle && !m_busy && !m_bv;
   endfunction

   always @(posedge clk) begin
      logic hs, loaded;
      if (reset) begin
         m_init = 1'b1; m_idle = 1'b1; m_busy = 1'b0; m_drop = 1'b0;
         m_bv = 1'b0; m_ov = 1'b0; m_mis = 1'b0;
         m_pc = 32'h0; m_opc = 32'h0; m_oin = '0; m_bpc = 32'h0; m_bin = '0;
      end else if (m_init) begin
         hs = exp_req() && ready;
         loaded = 1'b0;
         if (flush) begin
            m_ov   = 1'b0;
            m_bv   = 1'b0;
            m_busy = hs || (m_busy && !resp_valid);
            m_drop = m_busy;
`ifdef FETCH_MISALIGN_CHK_EN
            m_pc  = {flush_pc[31:2], 2'b00};
            m_mis = (flush_pc[1:0] != 2'b00);
`else
            m_pc  = flush_pc;
            m_mis = 1'b0;
`endif
         end else begin
            m_mis = 1'b0;
            if (m_busy && resp_valid) begin
               m_busy = 1'b0;
               if (m_drop) m_drop = 1'b0;
               else if (!stall) begin
                  m_opc = m_pc; m_oin = resp_data; m_ov = 1'b1; loaded = 1'b1;
                  m_pc = m_pc + 32'd4;
               end else begin
                  m_bv = 1'b1; m_bpc = m_pc; m_bin = resp_data;
               end
            end else if (m_bv && !stall) begin
               m_opc = m_bpc; m_oin = m_bin; m_ov = 1'b1; loaded = 1'b1; m_bv = 1'b0;
               m_pc = m_pc + 32'd4;
            end
            if (!loaded && !stall) m_ov = 1'b0;
            if (hs) m_busy = 1'b1;
         end
         m_idle = 1'b0;
      end
   end

   // ---------------- per-cycle compare ------------------------------------
   always @(negedge clk) begin
      if (m_init) begin
         chk("req_valid", imem_req_valid, exp_req());
         if (exp_req()) chk("req_addr", imem_req_addr, m_pc);
         chk("out_valid", pipeline_out_valid, m_ov);
         if (m_ov) begin
            chk("pc_out", PC_out, m_opc);
            chk("instr_out", instr_out, m_oin);
         end
         chk("misalign", fetch_misalign, m_mis);
      end
   end

   // Request addresses of the narrow-address instance.
   logic [7:0] q2[$];
   always @(negedge clk)
      if (!reset && req_valid2 && q2.size() < 2) q2.push_back(req_addr2);

   // ---------------- directed scenarios ----------------------------------
   int          vcyc[$];
   logic [31:0] vpc[$];
   logic        found;
   logic [31:0] tgt;

   task automatic wait_valid(string nm, logic [31:0] pc_exp, logic [31:0] in_exp);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (pipeline_out_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk({nm, "_seen"}, got, 1'b1);
      if (got) begin
         chk({nm, "_pc"}, PC_out, pc_exp);
         chk({nm, "_instr"}, instr_out, in_exp);
      end
   endtask

   initial begin
      // Reset state.
      reset = 1'b1; ready = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_pc_out", PC_out, 32'h0);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_valid", pipeline_out_valid, 1'b0);
      chk("rst_req", imem_req_valid, 1'b0);
      chk("rst_mis", fetch_misalign, 1'b0);
      tick();
      reset = 1'b0;

      // Streaming: 0,4,8 with one bubble between outputs.
      for (int i = 0; i < 40 && vpc.size() < 3; i++) begin
         @(negedge clk);
         if (pipeline_out_valid) begin
            vpc.push_back(PC_out);
            vcyc.push_back(i);
         end
      end
      chk("s1_count", vpc.size(), 3);
      for (int i = 0; i < vpc.size(); i++) chk("s1_pc", vpc[i], 32'(4 * i));
      for (int i = 1; i < vcyc.size(); i++) chk("s1_gap", vcyc[i] - vcyc[i-1], 2);

      // Park the 0x10 request, then accept it while stalled.
      tick();
      ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_addr == 32'h10) begin
            found = 1'b1;
            break;
         end
      end
      chk("s2_req10", found, 1'b1);
      tick();
      stall = 1'b1; ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("s2_hold_pc", PC_out, 32'h0C);
      chk("s2_hold_valid", pipeline_out_valid, 1'b0);
      chk("s2_hold_noreq", imem_req_valid, 1'b0);
      tick();
      stall = 1'b0;
      tick();
      stall = 1'b1; flush = 1'b1; flush_pc = 32'h102;
      @(negedge clk);
      chk("s2_out_valid", pipeline_out_valid, 1'b1);
      chk("s2_out_pc", PC_out, 32'h10);
      chk("s2_out_instr", instr_out, 32'hC0DE_0010);

      // Flush with stall over a valid output, misaligned target.
      tick();
      stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("s3_valid_drop", pipeline_out_valid, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("s3_mis_pulse", fetch_misalign, 1'b1);
      tgt = 32'h100;
`else
      chk("s3_mis_pulse", fetch_misalign, 1'b0);
      tgt = 32'h102;
`endif
      tick();
      @(negedge clk);
      chk("s3_mis_end", fetch_misalign, 1'b0);
      chk("s3_req_valid", imem_req_valid, 1'b1);
      chk("s3_req_addr", imem_req_addr, tgt);
      wait_valid("s3_first", tgt, tgt ^ 32'hC0DE_0000);

      // Flush in WAIT before the response (2-cycle memory): stale data drained.
      lat = 2;
      flush_pc = 32'h100;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req_valid && ready) begin
            found = 1'b1;
            break;
         end
      end
      chk("s4_hs", found, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      @(negedge clk);
      chk("s4_req_valid", imem_req_valid, 1'b1);
      chk("s4_req_addr", imem_req_addr, 32'h100);
      wait_valid("s4_first", 32'h100, 32'hC0DE_0100);

      // Narrow-address instance wraps 0xFC -> 0x00.
      chk("s5_count", q2.size(), 2);
      if (q2.size() > 0) chk("s5_first", q2[0], 32'hFC);
      if (q2.size() > 1) chk("s5_wrap", q2[1], 32'h00);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit.
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4: fetch address increment per accepted instruction.
REQ-003 clk  input  1  rising-edge clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 stall  input  1  downstream hold; the output register keeps its contents.
REQ-006 flush  input  1  redirect; discard in-flight work.
REQ-007 flush_pc  input  ADDR_SIZE+1  redirect target, sampled when flush=1.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_addr  output  ADDR_SIZE+1  fetch request address.
REQ-010 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-011 imem_resp_valid  input  1  single-cycle response strobe; cannot be backpressured.
REQ-012 imem_resp_data  input  INSTR_SIZE+1  returned instruction.
REQ-013 PC_out  output  ADDR_SIZE+1  address of the presented instruction.
REQ-014 instr_out  output  INSTR_SIZE+1  presented instruction.
REQ-015 pipeline_out_valid  output  1  PC_out/instr_out valid to decode.
REQ-016 fetch_misalign  output  1  misaligned redirect flag (see Configuration).

Function
REQ-017 At most one request is outstanding at any time.
REQ-018 FSM states are IDLE, REQ, WAIT, HOLD and DRAIN.
- IDLE -> REQ unconditionally.
- REQ: imem_req_valid=1 with addr=fetch_pc; on imem_req_ready -> WAIT.
- WAIT: on imem_resp_valid with stall=0 -> load the output register, then -> REQ; on imem_resp_valid with stall=1 -> capture into the buffer, then -> HOLD.
- HOLD: on stall=0 -> move the buffer to the output register, then -> REQ.
- DRAIN: on imem_resp_valid -> discard the data, then -> REQ.
REQ-019 Output register load writes PC_out=request address, instr_out=data and pipeline_out_valid=1 at the same edge; fetch_pc advances by PC_STEP at that edge.
REQ-020 Latency: response at cycle N with stall=0 gives pipeline_out_valid=1 in cycle N+1.
REQ-021 stall=1 holds PC_out, instr_out and pipeline_out_valid unchanged.
REQ-022 stall=0 with no load clears pipeline_out_valid to 0 (bubble).
REQ-023 A request handshake still completes in REQ while stall=1.
REQ-024 flush has priority over stall.
REQ-025 Effect of flush at the edge:
- pipeline_out_valid<=0 and fetch_pc<=flush_pc.
- The buffer is cleared.
- REQ with handshake this cycle, or WAIT without a response this cycle -> DRAIN.
- Otherwise -> REQ.
REQ-026 A response arriving in the same cycle as flush is discarded, and the state goes to REQ.
REQ-027 fetch_pc arithmetic is modulo 2^(ADDR_SIZE+1); PC wrap-around is silent.

Reset
REQ-028 Reset values: PC_out=0, instr_out=0, pipeline_out_valid=0, imem_req_valid=0, fetch_misalign=0, fetch_pc=RESET_PC, buffer empty, state IDLE.
REQ-029 reset overrides flush and stall.
REQ-030 Reset mid-WAIT does not guard against the stale response; the memory is reset in the same cycle.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHK_EN.
- Defined: a flush with flush_pc[1:0]!=0 loads fetch_pc with bits [1:0] cleared and sets fetch_misalign=1 for exactly one cycle.
- Undefined: flush_pc is loaded unmodified and fetch_misalign is tied 0.

Structure
REQ-032 ADDR_SIZE, INSTR_SIZE and the FSM state encodings are defined in the shared params file.
REQ-033 No sub-module is used; the buffer and the FSM are local to fetch_unit.

Verification
REQ-034 Reset, then memory ready=1 with 1-cycle response latency, stall=0 -> addresses 0,4,8 requested; PC_out 0,4,8 on consecutive valid outputs, with a one-bubble gap after each.
REQ-035 stall=1 across the response for addr 0x10 -> HOLD; PC_out unchanged; the 0x10 instruction appears the cycle after stall drops; no data is lost.
REQ-036 flush with flush_pc=0x100 while in WAIT -> the stale response is discarded (DRAIN); the next request is 0x100; the next valid PC_out is 0x100.
REQ-037 flush and stall both high while pipeline_out_valid=1 -> pipeline_out_valid=0 next cycle.
REQ-038 Configuration check, flush_pc=0x102:
- FETCH_MISALIGN_CHK_EN defined -> request 0x100 and a one-cycle fetch_misalign pulse.
- Undefined -> request 0x102 and fetch_misalign stays 0.
REQ-039 ADDR_SIZE=7 with RESET_PC=0xFC -> the next fetch after 0xFC is 0x00.
